// File: rtl/io_bus_responder.sv
// Memory-mapped I/O responder for the CPU data bus: LEDs, synchronized switches,
// a byte TX FIFO with a valid/ready drain port and an optional prescaled timer (IO_TIMER_EN).
module io_bus_responder #(
  parameter logic [7:0] IO_BASE    = 8'hFF,
  parameter int         LED_W      = 10,
  parameter int         SW_W       = 10,
  parameter int         FIFO_DEPTH = 8,
  parameter int         PRESCALE   = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       mem_addr,
  input  logic              mem_wr_en,
  input  logic [15:0]       mem_wr_data,
  output logic [15:0]       io_rd_data,
  output logic              io_hit,
  input  logic [SW_W-1:0]   sw,
  output logic [LED_W-1:0]  leds,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] PRESCALE_V = PRESCALE;

  // Address decode; bits [7:4] are ignored so registers alias across the window.
  logic       hit;
  logic [3:0] off;
  assign hit = (mem_addr[15:8] == IO_BASE);
  assign off = mem_addr[3:0];

  logic wr_led, wr_tx, wr_status;
  assign wr_led    = hit && mem_wr_en && (off == 4'h0);
  assign wr_tx     = hit && mem_wr_en && (off == 4'h2);
  assign wr_status = hit && mem_wr_en && (off == 4'h3);

  always_ff @(posedge clk) begin
    if (reset) begin
      leds <= '0;
    end else if (wr_led) begin
      leds <= mem_wr_data[LED_W-1:0];
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  logic [SW_W-1:0] sw_meta, sw_sync;
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // TX FIFO. Drain handshake: a byte transfers on every rising edge where
  // tx_valid && tx_ready; tx_valid/tx_data never depend on tx_ready.
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          full, empty, push, pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign push     = wr_tx && !full;
  assign tx_valid = !empty;
  assign pop      = tx_valid && tx_ready;
  assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_wr_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped push outranks a simultaneous clear.
      if (wr_status && mem_wr_data[3]) overflow <= 1'b0;
      if (wr_tx && full)               overflow <= 1'b1;
    end
  end

  logic status_flag;

`ifdef IO_TIMER_EN
  localparam int          PW       = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_TERM = PW'(PRESCALE - 1);

  logic          wr_tcount, wr_tcmp, wr_tctrl;
  logic [PW-1:0] presc;
  logic [15:0]   tcount, tcmp;
  logic          tenable, tflag, tick;

  assign wr_tcount = hit && mem_wr_en && (off == 4'h4);
  assign wr_tcmp   = hit && mem_wr_en && (off == 4'h5);
  assign wr_tctrl  = hit && mem_wr_en && (off == 4'h6);
  assign tick      = tenable && (presc == PRE_TERM);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      tcount  <= '0;
      tcmp    <= 16'hFFFF;
      tenable <= 1'b0;
      tflag   <= 1'b0;
    end else begin
      // A TCOUNT write restarts the timer and swallows any tick in that cycle.
      if (wr_tcount) begin
        presc  <= '0;
        tcount <= '0;
      end else if (tenable) begin
        if (tick) begin
          presc  <= '0;
          tcount <= tcount + 16'd1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
      if (wr_tcmp)  tcmp    <= mem_wr_data;
      if (wr_tctrl) tenable <= mem_wr_data[0];
      if (wr_status && mem_wr_data[2]) tflag <= 1'b0;
      if (tick && !wr_tcount && ((tcount + 16'd1) == tcmp)) tflag <= 1'b1;
    end
  end

  assign status_flag = tflag;
`else
  assign status_flag = 1'b0;
`endif

  // Read mux; reads never change state.
  logic [15:0] rd_next;
  always_comb begin
    rd_next = '0;
    case (off)
      4'h0: rd_next[LED_W-1:0] = leds;
      4'h1: rd_next[SW_W-1:0]  = sw_sync;
      4'h2: rd_next[AW:0]      = count;
      4'h3: rd_next[3:0]       = {overflow, status_flag, empty, full};
`ifdef IO_TIMER_EN
      4'h4: rd_next            = tcount;
      4'h5: rd_next            = tcmp;
      4'h6: rd_next[0]         = tenable;
`endif
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      io_rd_data <= '0;
      io_hit     <= 1'b0;
    end else begin
      io_rd_data <= hit ? rd_next : 16'h0000;
      io_hit     <= hit;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, mem_addr[7:4], mem_wr_data, PRESCALE_V};

endmodule
